// File: rtl/max_pool_2x2_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2_stream_if
//  Description : Stream bundle between a feature-map producer and the 2x2
//                max-pooling stage.
//                  in_valid   : In_OFM carries a sample this cycle
//                  In_OFM     : input sample, unsigned, raster order
//                  out_valid  : Out_Pool holds a pooled result
//                  Out_Pool   : pooled maximum
//                  frame_done : pulse with the last pooled output of a frame
//                master = side feeding samples in and observing results,
//                slave  = the pooling stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface max_pool_2x2_stream_if #(
    parameter int DATA_W = 36
);
    logic              in_valid;
    logic [DATA_W-1:0] In_OFM;
    logic              out_valid;
    logic [DATA_W-1:0] Out_Pool;
    logic              frame_done;

    modport master (
        output in_valid,
        output In_OFM,
        input  out_valid,
        input  Out_Pool,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  In_OFM,
        output out_valid,
        output Out_Pool,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/max_pool_2x2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2_stream
//  Description : Streaming 2x2 max pooling, stride 1, over an IMG_W x IMG_H
//                raster-order feature map. A one-row line buffer plus a
//                one-sample delay builds each 2x2 window as samples arrive.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                st     - stream bundle (slave side):
//                         in_valid/In_OFM in, out_valid/Out_Pool/frame_done
//                         out (all outputs registered, 1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module max_pool_2x2_stream #(
    parameter int DATA_W = 36,
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    max_pool_2x2_stream_if.slave   st
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COL_W-1:0]  col_q,       col_d;
    logic [ROW_W-1:0]  row_q,       row_d;
    logic [DATA_W-1:0] lb_q [IMG_W];
    logic [DATA_W-1:0] lb_d [IMG_W];
    logic [DATA_W-1:0] prev_top_q,  prev_top_d;
    logic [DATA_W-1:0] prev_cur_q,  prev_cur_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pool_q,  out_pool_d;
    logic              frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Window datapath. lb_q[col_q] is read before this cycle's write, so
    // it still holds the sample directly above the incoming one.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] top_right;
    logic [DATA_W-1:0] max_top;
    logic [DATA_W-1:0] max_bot;
    logic [DATA_W-1:0] win_max;
    logic              window_ok;
    logic              col_wrap;
    logic              frame_last;

    assign top_right  = lb_q[col_q];
    assign max_top    = (prev_top_q > top_right) ? prev_top_q : top_right;
    assign max_bot    = (prev_cur_q > st.In_OFM) ? prev_cur_q : st.In_OFM;
    assign win_max    = (max_top > max_bot) ? max_top : max_bot;
    // Row 0 and column 0 have no complete window above/left of them.
    assign window_ok  = (row_q != '0) && (col_q != '0);
    assign col_wrap   = (col_q == COL_LAST);
    assign frame_last = col_wrap && (row_q == ROW_LAST);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        lb_d         = lb_q;
        prev_top_d   = prev_top_q;
        prev_cur_d   = prev_cur_q;
        out_valid_d  = 1'b0;
        out_pool_d   = '0;
        frame_done_d = 1'b0;

        if (st.in_valid) begin
            lb_d[col_q] = st.In_OFM;
            prev_cur_d  = st.In_OFM;
            prev_top_d  = top_right;

            if (window_ok) begin
                out_valid_d  = 1'b1;
                out_pool_d   = win_max;
                frame_done_d = frame_last;
            end

            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb_q[i] <= '0;
            end
            prev_top_q   <= '0;
            prev_cur_q   <= '0;
            out_valid_q  <= 1'b0;
            out_pool_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            lb_q         <= lb_d;
            prev_top_q   <= prev_top_d;
            prev_cur_q   <= prev_cur_d;
            out_valid_q  <= out_valid_d;
            out_pool_q   <= out_pool_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign st.out_valid  = out_valid_q;
    assign st.Out_Pool   = out_pool_q;
    assign st.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_pool_2x2_stream
//  Description : Self-checking bench for max_pool_2x2_stream. A frame-level
//                reference holds the samples of the current frame in a 2D
//                array and computes each pooled value as the maximum of the
//                2x2 neighbourhood ending at the accepted sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_2x2_stream;

    localparam int DATA_W = 36;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam logic [DATA_W-1:0] DMAX = {DATA_W{1'b1}};

    logic clk;
    logic rst_n;

    max_pool_2x2_stream_if #(.DATA_W(DATA_W)) bus ();

    max_pool_2x2_stream #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    int n_fd     = 0;

    // Reference model state: samples of the frame in progress.
    logic [DATA_W-1:0] img [IMG_H][IMG_W];
    int                idx = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {DATA_W{1'b0}} | {$urandom, $urandom};
    endfunction

    // One clock cycle: present inputs, let the edge happen, check outputs.
    task automatic step(input bit v, input logic [DATA_W-1:0] d);
        bit                exp_v;
        bit                exp_fd;
        logic [DATA_W-1:0] exp_p;
        int                r;
        int                c;
        exp_v  = 1'b0;
        exp_fd = 1'b0;
        exp_p  = '0;
        bus.in_valid = v;
        bus.In_OFM   = v ? d : rand_data();
        if (v) begin
            r = idx / IMG_W;
            c = idx % IMG_W;
            img[r][c] = d;
            if (r > 0 && c > 0) begin
                exp_v  = 1'b1;
                exp_p  = max2(max2(img[r-1][c-1], img[r-1][c]), max2(img[r][c-1], img[r][c]));
                exp_fd = (idx == NPIX - 1);
            end
            idx = (idx + 1) % NPIX;
        end
        @(posedge clk);
        #1;
        check_val("out_valid",  64'(bus.out_valid),  64'(exp_v));
        check_val("Out_Pool",   64'(bus.Out_Pool),   64'(exp_p));
        check_val("frame_done", 64'(bus.frame_done), 64'(exp_fd));
        if (bus.out_valid)  n_out++;
        if (bus.frame_done) n_fd++;
    endtask

    // mode: 0 ramp, 1 descending, 2 single max at (2,2), 3 random
    function automatic logic [DATA_W-1:0] pix(input int mode, input int i);
        case (mode)
            0:       return DATA_W'(i);
            1:       return DATA_W'(NPIX - 1 - i);
            2:       return (i == 12) ? DMAX : '0;
            default: return rand_data();
        endcase
    endfunction

    // gap: 0 contiguous, 1 alternating idle plus 3-cycle gap mid-row 2, 2 random
    task automatic send_frame(input int mode, input int gap);
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, pix(mode, i));
            if (gap == 1) begin
                step(1'b0, '0);
                if (i == 11) begin
                    step(1'b0, '0);
                    step(1'b0, '0);
                end
            end else if (gap == 2) begin
                while ($urandom_range(0, 3) == 0) step(1'b0, '0);
            end
        end
    endtask

    task automatic frame_counts(input string tag, input int out_exp, input int fd_exp);
        check_val({tag, "_outputs"}, 64'(n_out), 64'(out_exp));
        check_val({tag, "_frame_done"}, 64'(n_fd), 64'(fd_exp));
        n_out = 0;
        n_fd  = 0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.In_OFM   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out_valid",  64'(bus.out_valid),  64'd0);
        check_val("reset_Out_Pool",   64'(bus.Out_Pool),   64'd0);
        check_val("reset_frame_done", 64'(bus.frame_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0);

        send_frame(0, 0); frame_counts("ramp", 16, 1);
        send_frame(1, 0); frame_counts("desc", 16, 1);
        send_frame(0, 1); frame_counts("ramp_gaps", 16, 1);
        send_frame(2, 0); frame_counts("single_max", 16, 1);
        send_frame(0, 0);
        send_frame(0, 0); frame_counts("back_to_back", 32, 2);

        // Partial frame A, then asynchronous reset between edges.
        for (int i = 0; i < 13; i++) step(1'b1, DATA_W'(100 + i));
        check_val("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(bus.out_valid),  64'd0);
        check_val("async_rst_pool",  64'(bus.Out_Pool),   64'd0);
        check_val("async_rst_fd",    64'(bus.frame_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idx   = 0;
        n_out = 0;
        n_fd  = 0;
        step(1'b0, '0);
        send_frame(0, 0); frame_counts("after_reset", 16, 1);

        for (int f = 0; f < 6; f++) begin
            send_frame(3, 2);
            frame_counts("random", 16, 1);
        end
        for (int k = 0; k < 4; k++) step(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/max_pool_2x2_stream.md
# max_pool_2x2_stream

Streaming 2x2 max-pooling stage (stride 1) that consumes the serial 5x5 output feature map of the 3x3 convolution stage and emits a 4x4 pooled map. Samples arrive one per valid cycle in raster order. A one-row line buffer plus a one-sample delay forms each 2x2 window on the fly, with no full-frame storage. It sits directly downstream of the convolution block and connects to its `out_valid` / `Out_OFM` pair without glue logic.

## Interface
- `DATA_W`, 36: sample width in bits; unsigned.
- `IMG_W`, 5: input row length in samples; minimum 2.
- `IMG_H`, 5: input rows per frame; minimum 2.

- `clk`  in  1: clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `In_OFM` carries a sample this cycle.
- `In_OFM`  in  `DATA_W`: input sample, unsigned, raster order.
- `out_valid`  out  1: registered; `Out_Pool` holds a pooled result.
- `Out_Pool`  out  `DATA_W`: registered pooled maximum.
- `frame_done`  out  1: registered one-cycle pulse coinciding with the last pooled output of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on cycles with `in_valid`=1. `col` wraps to 0 and increments `row`. After (IMG_H-1, IMG_W-1), both wrap to 0.
- `in_valid` gaps are legal anywhere, including mid-row. During a gap, all state holds.
- There is no ready or backpressure. Every valid sample is accepted.
- Line buffer `lb[0..IMG_W-1]`: on each accepted sample, `lb[col]` <= `In_OFM`. Before that write, `lb[col]` still holds the previous row's sample at `col`.
- Delay register `prev_cur` <= `In_OFM` on each accepted sample. `prev_top` <= old `lb[col]` on each accepted sample.
- Window formed on each accepted sample with `row`>=1 and `col`>=1:
  - top-left = `prev_top`
  - top-right = old `lb[col]`
  - bottom-left = `prev_cur`
  - bottom-right = `In_OFM`
- Result = unsigned maximum of the four values. Ties return the shared value. There is no sign handling, no truncation, and width stays `DATA_W`.
- Samples in row 0 or column 0 update state only and produce no output.
- Outputs per frame: (IMG_W-1)*(IMG_H-1) = 16 at default parameters.
- Out-of-range state cannot occur because the counters wrap explicitly. A new frame may begin on the cycle immediately after the last sample of the previous frame, with no idle cycle required.
- Reset mid-frame:
  - Counters, `lb`, `prev_top`, `prev_cur` and all outputs clear to 0.
  - The next accepted sample is treated as (0,0) of a new frame.
  - The partial frame is discarded with no outputs.

## Timing
- Reset values: `out_valid`=0, `Out_Pool`=0, `frame_done`=0. Counters and buffers are also 0.
- Latency: a sample accepted at edge N that completes a window produces `out_valid`=1 with `Out_Pool`=max in the cycle after edge N. Latency is 1 cycle.
- `out_valid` is high for exactly one cycle per pooled result.
- With contiguous input, outputs for a row are back-to-back: IMG_W-1 consecutive cycles, then 1 idle cycle at each column-0 sample.
- `Out_Pool` is 0 whenever `out_valid`=0.
- `frame_done`=1 only in the same cycle as the output produced by sample (IMG_H-1, IMG_W-1).
- Continuous 25-sample input: first output one cycle after sample index 6 is accepted; last output one cycle after sample 24.

## Test plan
- Ramp frame 0..24, contiguous `in_valid` -> 16 outputs: 6,7,8,9, 11,12,13,14, 16,17,18,19, 21,22,23,24. `frame_done` coincides with 24. No output during row 0 or at column-0 samples.
- Descending frame 24..0 -> outputs 24,23,22,21, 19,18,17,16, 14,13,12,11, 9,8,7,6. Checks that the top-left (line buffer/delay) path is selected.
- Ramp frame with `in_valid` toggling 1,0,1,0 and a 3-cycle gap mid-row 2 -> identical 16 values in the same order. Each output appears exactly 1 cycle after its completing sample. `Out_Pool`=0 during gaps.
- All zeros except sample 12 (row 2, col 2) = 2^36-1 -> outputs 0,0,0,0, 0,max,max,0, 0,max,max,0, 0,0,0,0. Checks full-width compare with no truncation.
- Two ramp frames back-to-back with no idle cycle -> 32 outputs. The second frame matches the first exactly, and `frame_done` pulses twice. Confirms the line buffer does not corrupt row 0 of frame 2.
- Assert `rst_n`=0 asynchronously after 13 samples of frame A (mid-cycle, between edges), then release and send a ramp frame -> outputs drop to 0 immediately on reset. Frame A yields no further outputs, and the new frame produces the ramp sequence 6..24.
